// File: rtl/nuc_pattern_engine.sv
// rtl/nuc_pattern_engine.sv - programmable nucleotide pattern matcher over a valid/ready stream
// Optional bounded-repeat opcode 0x5k and the REP_UPTO state are built only when PATCHK_UPTO_EN is defined.
module nuc_pattern_engine #(
  parameter int NW    = 2,
  parameter int PW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [PW-1:0] prog_data,
  input  logic          nuc_valid,
  input  logic [NW-1:0] nuc,
  output logic          nuc_ready,
  output logic          done,
  output logic          matched,
  output logic          error,
  output logic [AW-1:0] fail_pc,
  output logic [7:0]    consumed
);

  localparam int OW = PW - 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SKIP,
    S_REP_EXACT,
`ifdef PATCHK_UPTO_EN
    S_REP_UPTO,
`endif
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n, pc_inc;
  logic [OW-1:0] cnt, cnt_n;
  logic [PW-1:0] prog [DEPTH];

  logic [3:0]    op, nop;
  logic [OW-1:0] arg;
  logic          pc_last, nlit, match, hs, idle_like;
  logic          adv, fin, fin_match, fin_err;

  // Opcode lives in the top nibble, operand in the low PW-4 bits.
  assign op        = prog[pc][PW-1:PW-4];
  assign arg       = prog[pc][OW-1:0];
  assign pc_last   = (pc == AW'(DEPTH - 1));
  assign pc_inc    = pc_last ? '0 : pc + 1'b1;
  assign nop       = prog[pc_inc][PW-1:PW-4];
  assign nlit      = (nop == 4'h1);
  assign match     = (OW'(nuc) == arg);
  assign hs        = nuc_valid & nuc_ready;
  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    cnt_n     = cnt;
    nuc_ready = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    fin_match = 1'b0;
    fin_err   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_EXEC;
          pc_n    = '0;
          cnt_n   = '0;
        end
      end
      S_EXEC: begin
        case (op)
          4'h0: begin
            fin = 1'b1;
            if (arg == '0) fin_match = 1'b1;
            else           fin_err   = 1'b1;
          end
          4'h1: begin
            nuc_ready = 1'b1;
            if (nuc_valid) begin
              if (match) adv = 1'b1;
              else       fin = 1'b1;
            end
          end
          4'h2: begin
            if (arg <= OW'(2)) begin
              cnt_n   = arg + 1'b1;
              state_n = S_SKIP;
            end else begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          end
          4'h4: begin
            if (arg == '0 || pc_last || !nlit) begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end else begin
              cnt_n   = arg;
              pc_n    = pc_inc;
              state_n = S_REP_EXACT;
            end
          end
`ifdef PATCHK_UPTO_EN
          4'h5: begin
            if (pc_last || !nlit) begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end else begin
              cnt_n   = arg;
              pc_n    = pc_inc;
              state_n = S_REP_UPTO;
            end
          end
`endif
          default: begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        endcase
      end
      S_SKIP: begin
        nuc_ready = 1'b1;
        if (nuc_valid) begin
          cnt_n = cnt - 1'b1;
          if (cnt == OW'(1)) adv = 1'b1;
        end
      end
      S_REP_EXACT: begin
        nuc_ready = 1'b1;
        if (nuc_valid) begin
          if (!match) begin
            fin = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
            if (cnt == OW'(1)) adv = 1'b1;
          end
        end
      end
`ifdef PATCHK_UPTO_EN
      // A mismatching nucleotide is left on the stream for the next instruction.
      S_REP_UPTO: begin
        nuc_ready = nuc_valid & match & (cnt != '0);
        if (cnt == '0) begin
          adv = 1'b1;
        end else if (nuc_valid) begin
          if (match) cnt_n = cnt - 1'b1;
          else       adv   = 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      if (pc_last) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else begin
        pc_n    = pc_inc;
        state_n = S_EXEC;
      end
    end
    if (fin) state_n = S_DONE;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state    <= S_IDLE;
      pc       <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      matched  <= 1'b0;
      error    <= 1'b0;
      fail_pc  <= '0;
      consumed <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      if (idle_like && start) begin
        done     <= 1'b0;
        matched  <= 1'b0;
        error    <= 1'b0;
        consumed <= '0;
      end else begin
        if (hs && consumed != 8'hff) consumed <= consumed + 8'd1;
        if (fin) begin
          done    <= 1'b1;
          matched <= fin_match;
          error   <= fin_err;
          fail_pc <= pc;
        end
      end
    end
  end

  // Writes land at the same edge that launches a run, so the run sees them.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) prog[i] <= '0;
    end else if (idle_like && prog_we && (int'(prog_addr) < DEPTH)) begin
      prog[prog_addr] <= prog_data;
    end
  end

endmodule

// File: doc/nuc_pattern_engine.md
NUC_PATTERN_ENGINE -- requirements
Module: nuc_pattern_engine

Interface
REQ-001 SHALL have parameter NW, default 2, meaning nucleotide width in bits.
REQ-002 SHALL have parameter PW, default 8, meaning pattern word width; NW <= PW-4.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of program words; AW = $clog2(DEPTH).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, on ports named as follows:
  - clock  input  1  sole clock; all state changes on its rising edge.
  - reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have the remaining ports:
  - start  input  1  begin a match run at pc 0.
  - prog_we  input  1  program word write enable.
  - prog_addr  input  AW  program write address.
  - prog_data  input  PW  program write data.
  - nuc_valid  input  1  nuc stream word valid.
  - nuc  input  NW  nucleotide.
  - nuc_ready  output  1  engine accepts nuc this cycle.
  - done  output  1  run finished; held until next start.
  - matched  output  1  run finished with a full match.
  - error  output  1  run finished on an illegal program.
  - fail_pc  output  AW  pc at which the run terminated.
  - consumed  output  8  nucleotides accepted this run; saturates at 255.

Function
REQ-006 SHALL hold DEPTH x PW program registers; a write occurs when prog_we=1 in IDLE or DONE, and is ignored otherwise.
REQ-007 SHALL implement states IDLE, EXEC, SKIP, REP_EXACT, REP_UPTO and DONE.
REQ-008 SHALL, when start=1 in IDLE or DONE, go to EXEC, set pc=0, consumed=0, and clear done, matched and error; start SHALL be ignored in any other state.
REQ-009 SHALL, on a same-cycle prog_we and start, commit the write first, so the run sees the new word.
REQ-010 SHALL define a handshake as nuc_valid & nuc_ready in one cycle; each handshake increments consumed by exactly 1.
REQ-011 SHALL execute the opcode at prog[pc] in EXEC combinationally, as follows:
  - 0x00 END: -> DONE, matched=1, no nucleotide consumed.
  - 0x1n LIT: nuc_ready=1; on handshake, nuc==n -> pc+1; otherwise -> DONE, matched=0.
  - 0x20/0x21/0x22 ANY1/2/3: load cnt=1/2/3 -> SKIP; each handshake decrements cnt; cnt reaching 0 -> pc+1, EXEC.
  - 0x4k EXACT: require k != 0 and prog[pc+1] to be LIT, else error; load cnt=k, pc+1 -> REP_EXACT.
  - 0x5k UPTO: require prog[pc+1] to be LIT, else error; load cnt=k, pc+1 -> REP_UPTO.
  - Any other opcode -> DONE, error=1.
REQ-012 SHALL, in REP_EXACT, set nuc_ready=1 and compare each handshake against the LIT operand; a mismatch -> DONE, matched=0; the last match -> pc+1, EXEC.
REQ-013 SHALL, in REP_UPTO, drive nuc_ready = nuc_valid & (nuc==operand) & (cnt!=0).
  - On a handshake: decrement cnt.
  - When cnt==0, or nuc_valid with a mismatch: go to pc+1, EXEC, without consuming the mismatching nucleotide.
REQ-014 SHALL stall with no state change while nuc_valid=0 in any consuming state.
REQ-015 SHALL treat pc advancing past DEPTH-1 without END, or an operand fetch beyond DEPTH-1, as error -> DONE.
REQ-016 SHALL set fail_pc to pc on entering DONE: the END, failing LIT or illegal word address.
REQ-017 SHALL drive nuc_ready=0 in IDLE and DONE.
REQ-018 SHALL hold done, matched, error, fail_pc and consumed stable in DONE until start.

Reset
REQ-019 SHALL, on reset_L=0, immediately set the following, including mid-run:
  - state=IDLE, pc=0, cnt=0, all program words=0.
  - done=0, matched=0, error=0, fail_pc=0, consumed=0, nuc_ready=0.

Configuration
REQ-020 SHALL, with macro PATCHK_UPTO_EN defined, support opcode 0x5k per REQ-011 and REQ-013; without it, 0x5k SHALL be illegal (error), and REP_UPTO logic SHALL be absent.

Verification
REQ-021 Program {11,12,00}, stream 1,2 -> done=1, matched=1, consumed=2, fail_pc=2.
REQ-022 Program {13,00}, stream 0 -> done=1, matched=0, error=0, consumed=1, fail_pc=0.
REQ-023 Program {43,12,00}, stream 2,2,2 with nuc_valid low for 2 cycles mid-stream -> matched=1, consumed=3.
REQ-024 Program {53,11,10,00}, stream 1,0 -> matched=1, consumed=2; nuc_ready=0 on the 0 while in REP_UPTO.
REQ-025 Program {40,...} -> error=1, fail_pc=0; without PATCHK_UPTO_EN, program {52,11,00} -> error=1, fail_pc=0.
REQ-026 reset_L=0 mid-REP_EXACT -> all outputs 0 in the same cycle; the following start runs an all-END program -> matched=1, consumed=0.
